// File: rtl/opb_cfg_master.sv
// Single-beat OPB master for the QDR sniffer config-register slaves.
// Takes one read/write command at a time from a local sequencer, requests the bus,
// performs the transfer and returns a one-cycle completion pulse with data and status.
// Slave retry, error-ack and a transfer timeout are handled so the sequencer never hangs.
//
// Optional feature macro: OPB_CFG_MASTER_RETRY_CAP_EN
//   defined   - a retry seen when MAX_RETRY-1 retries have already happened ends the
//               command with rsp_err=1 instead of re-requesting the bus.
//   undefined - retries are unlimited and no retry counter exists.
module opb_cfg_master #(
    parameter int unsigned C_OPB_AWIDTH   = 32,
    parameter int unsigned C_OPB_DWIDTH   = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned MAX_RETRY      = 4
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    // Local command / response interface
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_rnw,
    input  logic [0:C_OPB_AWIDTH-1]     cmd_addr,
    input  logic [0:C_OPB_DWIDTH-1]     cmd_wdata,
    input  logic [0:C_OPB_DWIDTH/8-1]   cmd_be,
    output logic                        rsp_valid,
    output logic [0:C_OPB_DWIDTH-1]     rsp_rdata,
    output logic                        rsp_err,
    output logic                        rsp_tout,
    // OPB master side
    output logic                        M_request,
    output logic                        M_select,
    output logic                        M_RNW,
    output logic [0:C_OPB_AWIDTH-1]     M_ABus,
    output logic [0:C_OPB_DWIDTH-1]     M_DBus,
    output logic [0:C_OPB_DWIDTH/8-1]   M_BE,
    output logic                        M_seqAddr,
    input  logic                        OPB_MGrant,
    input  logic                        OPB_xferAck,
    input  logic                        OPB_errAck,
    input  logic                        OPB_retry,
    input  logic                        OPB_toutSup,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus
);

    // Elaboration-time parameter range checks
    if (C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32) begin : g_bad_width
        $error("opb_cfg_master: OPB address and data widths are fixed at 32");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("opb_cfg_master: TIMEOUT_CYCLES must be in 2..255");
    end
    if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_retry
        $error("opb_cfg_master: MAX_RETRY must be in 1..15");
    end

    localparam int unsigned BW = C_OPB_DWIDTH / 8;

    // Last XFER cycle count before the master gives up on a silent slave
    localparam logic [7:0] TOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

`ifdef OPB_CFG_MASTER_RETRY_CAP_EN
    localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRY - 1);
`endif

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StXfer,
        StResp
    } state_e;

    state_e                     r_state;
    state_e                     w_state_nxt;

    logic                       r_rnw;
    logic                       w_rnw_nxt;
    logic [0:C_OPB_AWIDTH-1]    r_addr;
    logic [0:C_OPB_AWIDTH-1]    w_addr_nxt;
    logic [0:C_OPB_DWIDTH-1]    r_wdata;
    logic [0:C_OPB_DWIDTH-1]    w_wdata_nxt;
    logic [0:BW-1]              r_be;
    logic [0:BW-1]              w_be_nxt;
    logic [0:C_OPB_DWIDTH-1]    r_rdata;
    logic [0:C_OPB_DWIDTH-1]    w_rdata_nxt;
    logic                       r_err;
    logic                       w_err_nxt;
    logic                       r_tout;
    logic                       w_tout_nxt;
    logic [7:0]                 r_tout_cnt;
    logic [7:0]                 w_tout_cnt_nxt;
`ifdef OPB_CFG_MASTER_RETRY_CAP_EN
    logic [3:0]                 r_retry_cnt;
    logic [3:0]                 w_retry_cnt_nxt;
`endif

    logic                       w_sel;

    // State register
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath next values; xferAck beats retry beats timeout
    always_comb begin
        w_state_nxt    = r_state;
        w_rnw_nxt      = r_rnw;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_be_nxt       = r_be;
        w_rdata_nxt    = r_rdata;
        w_err_nxt      = r_err;
        w_tout_nxt     = r_tout;
        w_tout_cnt_nxt = r_tout_cnt;
`ifdef OPB_CFG_MASTER_RETRY_CAP_EN
        w_retry_cnt_nxt = r_retry_cnt;
`endif
        unique case (r_state)
            StIdle: begin
                if (cmd_valid) begin
                    w_rnw_nxt      = cmd_rnw;
                    w_addr_nxt     = cmd_addr;
                    w_wdata_nxt    = cmd_wdata;
                    w_be_nxt       = cmd_be;
                    // Writes and aborted reads report zero data
                    w_rdata_nxt    = '0;
                    w_err_nxt      = 1'b0;
                    w_tout_nxt     = 1'b0;
                    w_tout_cnt_nxt = '0;
`ifdef OPB_CFG_MASTER_RETRY_CAP_EN
                    w_retry_cnt_nxt = '0;
`endif
                    w_state_nxt    = StReq;
                end
            end
            StReq: begin
                if (OPB_MGrant) begin
                    w_state_nxt = StXfer;
                end
            end
            StXfer: begin
                if (!OPB_toutSup) begin
                    w_tout_cnt_nxt = r_tout_cnt + 8'd1;
                end
                if (OPB_xferAck) begin
                    if (r_rnw) begin
                        w_rdata_nxt = OPB_DBus;
                    end
                    w_err_nxt   = OPB_errAck;
                    w_state_nxt = StResp;
                end else if (OPB_retry) begin
`ifdef OPB_CFG_MASTER_RETRY_CAP_EN
                    if (r_retry_cnt == RETRY_LAST) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = StResp;
                    end else begin
                        w_retry_cnt_nxt = r_retry_cnt + 4'd1;
                        w_tout_cnt_nxt  = '0;
                        w_state_nxt     = StReq;
                    end
`else
                    w_tout_cnt_nxt = '0;
                    w_state_nxt    = StReq;
`endif
                end else if (!OPB_toutSup && (r_tout_cnt == TOUT_LAST)) begin
                    w_tout_nxt  = 1'b1;
                    w_state_nxt = StResp;
                end
            end
            StResp: begin
                w_err_nxt   = 1'b0;
                w_tout_nxt  = 1'b0;
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Command latch, response and counter registers
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_rnw      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_tout     <= 1'b0;
            r_tout_cnt <= '0;
`ifdef OPB_CFG_MASTER_RETRY_CAP_EN
            r_retry_cnt <= '0;
`endif
        end else begin
            r_rnw      <= w_rnw_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_be       <= w_be_nxt;
            r_rdata    <= w_rdata_nxt;
            r_err      <= w_err_nxt;
            r_tout     <= w_tout_nxt;
            r_tout_cnt <= w_tout_cnt_nxt;
`ifdef OPB_CFG_MASTER_RETRY_CAP_EN
            r_retry_cnt <= w_retry_cnt_nxt;
`endif
        end
    end

    assign w_sel = (r_state == StXfer);

    // Bus outputs are forced to zero when not selected so they can be OR-ed onto the OPB;
    // the data bus is only driven for writes since the slave owns it during reads.
    assign cmd_ready = (r_state == StIdle);
    assign M_request = (r_state == StReq);
    assign M_select  = w_sel;
    assign M_RNW     = w_sel & r_rnw;
    assign M_ABus    = w_sel ? r_addr : '0;
    assign M_DBus    = (w_sel && !r_rnw) ? r_wdata : '0;
    assign M_BE      = w_sel ? r_be : '0;
    assign M_seqAddr = 1'b0;
    assign rsp_valid = (r_state == StResp);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign rsp_tout  = r_tout;

endmodule

// File: doc/opb_cfg_master.md
Name: opb_cfg_master

Overview:
- Single-beat OPB master (initiator) for the config-register slaves in the QDR sniffer pcore: delay-enable, reset and status registers.
- Accepts one read or write command at a time from a local sequencer, for example a delay-tap calibration walker.
- Arbitrates for the OPB, performs the transfer and returns read data with completion status.
- Handles slave retry, error-ack and timeout so the sequencer never hangs on a dead address.

Parameters:
C_OPB_AWIDTH, 32, OPB address width (fixed at 32)
C_OPB_DWIDTH, 32, OPB data width (fixed at 32)
TIMEOUT_CYCLES, 16, cycles in XFER without xferAck before timeout; legal 2..255
MAX_RETRY, 4, retry limit when OPB_CFG_MASTER_RETRY_CAP_EN is defined; legal 1..15

Ports:
OPB_Clk  in  1  sole clock
OPB_Rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_rnw  in  1  1=read, 0=write
cmd_addr  in  32  byte address
cmd_wdata  in  32  write data, bit 31 = LSB (maps to OPB bit 31)
cmd_be  in  4  byte enables, bit 3 = OPB_BE[3]
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  read data, valid with rsp_valid
rsp_err  out  1  slave errAck seen, or retry limit hit
rsp_tout  out  1  timeout
M_request  out  1  bus request
M_select  out  1  master select
M_RNW  out  1  read/not-write
M_ABus  out  [0:31]  address
M_DBus  out  [0:31]  write data
M_BE  out  [0:3]  byte enables
M_seqAddr  out  1  tied 0
OPB_MGrant  in  1  grant
OPB_xferAck  in  1  slave ack
OPB_errAck  in  1  slave error
OPB_retry  in  1  slave retry
OPB_toutSup  in  1  timeout suppress
OPB_DBus  in  [0:31]  read data

Behaviour:
- Reset (synchronous): state=IDLE.
  - Deasserted: all M_* outputs, rsp_valid, rsp_err, rsp_tout.
  - Zeroed: M_ABus, M_DBus, M_BE, rsp_rdata.
  - cmd_ready=1 on the first cycle after reset.
  - Reset mid-transfer aborts with no rsp_valid.
- M_ABus, M_DBus, M_BE and M_RNW are zero whenever M_select=0 (OR-bus rule).
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch rnw/addr/wdata/be, clear retry_cnt and tout_cnt, go to REQ. cmd_ready drops the next cycle.
- REQ:
  - M_request=1.
  - When OPB_MGrant=1 is sampled, go to XFER. M_request drops in XFER.
- XFER:
  - M_select=1 and address/data/BE/RNW driven.
  - tout_cnt increments each cycle unless OPB_toutSup=1, which holds it.
  - Priority is xferAck > retry > timeout.
  - OPB_xferAck=1: capture OPB_DBus into rsp_rdata if read (writes leave rsp_rdata at 0), set rsp_err=OPB_errAck, go to RESP.
  - OPB_retry=1 without xferAck: retry_cnt++, tout_cnt=0, go to REQ with M_select=0 next cycle.
  - tout_cnt reaches TIMEOUT_CYCLES-1 with no ack and toutSup=0: set rsp_tout=1, go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle with rsp_rdata/err/tout stable, then IDLE.
  - rsp_err and rsp_tout clear on return to IDLE.
- Minimum latency with grant and ack each arriving on their first possible cycle:
  - Edge 0: cmd accepted.
  - Edge 1: request sampled with grant.
  - Edge 2: xferAck sampled.
  - Cycle 3: rsp_valid.
  - Next command can be accepted at edge 4.
- A xferAck outside XFER is ignored.
- A command presented while busy is held off via cmd_ready=0, never dropped.

Optional Feature:
OPB_CFG_MASTER_RETRY_CAP_EN:
- Defined: a retry when retry_cnt==MAX_RETRY-1 ends the transaction with rsp_err=1, rsp_tout=0, rsp_rdata=0, and the bus is not re-requested.
- Undefined: retries are unlimited; retry_cnt is not implemented.

Test Plan:
- Write addr 0x0000_001C, wdata 0x1, be 0xF; grant same cycle, ack next -> M_select high 1 cycle, M_DBus[31]=1, M_RNW=0; rsp_valid at cycle 3, rsp_err=0, rsp_tout=0.
- Read addr 0x0000_0004, slave returns 0x0000_0101 with ack after 3 select cycles -> rsp_rdata=0x0000_0101, one rsp_valid pulse, bus outputs 0 afterwards.
- Read with no ack and toutSup=0 -> select held 16 cycles, rsp_tout=1, rsp_rdata=0; repeat with toutSup high for 20 cycles then ack -> no timeout, data returned.
- Retry asserted on 2 transfers, then ack -> M_request re-asserted twice, rsp_err=0. With the macro defined and retry on every attempt -> 4 attempts, then rsp_err=1.
- errAck+xferAck together on a write -> rsp_err=1, rsp_valid 1 cycle; next command accepted.
- Assert OPB_Rst while in XFER -> next edge M_select=0, M_request=0, cmd_ready=1, no rsp_valid; back-to-back commands with cmd_valid held high -> exactly one rsp_valid per command.
